// File: rtl/pwm_capture.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pwm_capture                                                  |
// | Description : Measures high time, period and duty cycle (x/256) of an       |
// |               asynchronous PWM input, with a per-measurement cycle timeout.|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pwm_capture #(
    parameter logic [15:0] TIMEOUT = 16'd65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pwm_in,
    input  logic        meas_start,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [15:0] high_cnt,
    output logic [15:0] period_cnt,
    output logic [7:0]  duty
);

    localparam logic [2:0] c_s_idle      = 3'd0;
    localparam logic [2:0] c_s_wait_rise = 3'd1;
    localparam logic [2:0] c_s_meas_high = 3'd2;
    localparam logic [2:0] c_s_meas_low  = 3'd3;
    localparam logic [2:0] c_s_divide    = 3'd4;
    localparam logic [2:0] c_s_done      = 3'd5;

    // Abort fires on the cycle whose increment would reach TIMEOUT.
    localparam logic [15:0] c_tmo_last = TIMEOUT - 16'd1;

    logic [2:0]  r_state;
    logic [2:0]  w_next_state;

    logic        r_sync1;
    logic        r_sync2;
    logic        r_sync_d;
    logic        w_rise;
    logic        w_fall;
    logic        w_measuring;
    logic        w_tmo_hit;

    logic [15:0] r_cnt;
    logic [15:0] r_tmo;
    logic [15:0] r_high_meas;
    logic [15:0] r_period_meas;
    logic [15:0] r_rem;
    logic [6:0]  r_quo;
    logic [2:0]  r_div_cnt;

    logic [16:0] w_rem_sh;
    logic        w_sub_ok;
    logic [15:0] w_rem_next;
    logic [7:0]  w_quo_next;
    logic        w_div_last;

    logic        r_timeout;
    logic [15:0] r_high_cnt;
    logic [15:0] r_period_cnt;
    logic [7:0]  r_duty;

    assign w_rise      = r_sync2 & ~r_sync_d;
    assign w_fall      = ~r_sync2 & r_sync_d;
    assign w_measuring = (r_state == c_s_wait_rise) || (r_state == c_s_meas_high) ||
                         (r_state == c_s_meas_low);
    assign w_tmo_hit   = w_measuring && (r_tmo == c_tmo_last);

    // One restoring-division step: remainder is always below the period, so the
    // shifted value fits in 17 bits and the difference fits back in 16.
    assign w_rem_sh   = {r_rem, 1'b0};
    assign w_sub_ok   = (w_rem_sh >= {1'b0, r_period_meas});
    assign w_rem_next = w_sub_ok ? (w_rem_sh[15:0] - r_period_meas) : w_rem_sh[15:0];
    assign w_quo_next = {r_quo, w_sub_ok};
    assign w_div_last = (r_div_cnt == 3'd7);

    assign busy       = w_measuring || (r_state == c_s_divide);
    assign done       = (r_state == c_s_done);
    assign timeout    = r_timeout;
    assign high_cnt   = r_high_cnt;
    assign period_cnt = r_period_cnt;
    assign duty       = r_duty;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_s_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; a timeout abort takes priority over any edge event.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_s_idle: begin
                if (meas_start) w_next_state = c_s_wait_rise;
            end
            c_s_wait_rise: begin
                if (w_tmo_hit)   w_next_state = c_s_done;
                else if (w_rise) w_next_state = c_s_meas_high;
            end
            c_s_meas_high: begin
                if (w_tmo_hit)   w_next_state = c_s_done;
                else if (w_fall) w_next_state = c_s_meas_low;
            end
            c_s_meas_low: begin
                if (w_tmo_hit)   w_next_state = c_s_done;
                else if (w_rise) w_next_state = c_s_divide;
            end
            c_s_divide: begin
                if (w_div_last) w_next_state = c_s_done;
            end
            c_s_done: begin
                w_next_state = meas_start ? c_s_wait_rise : c_s_idle;
            end
            default: w_next_state = c_s_idle;
        endcase
    end

    // Synchronizer, counters, divider and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1       <= 1'b0;
            r_sync2       <= 1'b0;
            r_sync_d      <= 1'b0;
            r_cnt         <= 16'd0;
            r_tmo         <= 16'd0;
            r_high_meas   <= 16'd0;
            r_period_meas <= 16'd0;
            r_rem         <= 16'd0;
            r_quo         <= 7'd0;
            r_div_cnt     <= 3'd0;
            r_timeout     <= 1'b0;
            r_high_cnt    <= 16'd0;
            r_period_cnt  <= 16'd0;
            r_duty        <= 8'd0;
        end else begin
            r_sync1  <= pwm_in;
            r_sync2  <= r_sync1;
            r_sync_d <= r_sync2;
            case (r_state)
                c_s_idle, c_s_done: begin
                    if (meas_start) begin
                        r_tmo     <= 16'd0;
                        r_timeout <= 1'b0;
                    end
                end
                c_s_wait_rise: begin
                    r_tmo <= r_tmo + 16'd1;
                    // Rise-detect cycle is cycle 0, so the next cycle counts 1.
                    if (w_rise) r_cnt <= 16'd1;
                end
                c_s_meas_high: begin
                    r_tmo <= r_tmo + 16'd1;
                    r_cnt <= r_cnt + 16'd1;
                    if (w_fall) r_high_meas <= r_cnt;
                end
                c_s_meas_low: begin
                    r_tmo <= r_tmo + 16'd1;
                    r_cnt <= r_cnt + 16'd1;
                    if (w_rise) begin
                        r_period_meas <= r_cnt;
                        r_rem         <= r_high_meas;
                        r_quo         <= 7'd0;
                        r_div_cnt     <= 3'd0;
                    end
                end
                c_s_divide: begin
                    r_rem     <= w_rem_next;
                    r_quo     <= w_quo_next[6:0];
                    r_div_cnt <= r_div_cnt + 3'd1;
                    if (w_div_last) begin
                        r_high_cnt   <= r_high_meas;
                        r_period_cnt <= r_period_meas;
                        r_duty       <= w_quo_next;
                        r_timeout    <= 1'b0;
                    end
                end
                default: ;
            endcase
            if (w_tmo_hit) begin
                r_high_cnt   <= 16'd0;
                r_period_cnt <= 16'd0;
                r_duty       <= r_sync2 ? 8'hFF : 8'h00;
                r_timeout    <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pwm_capture.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pwm_capture                                               |
// | Description : Directed self-checking bench for pwm_capture.                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_pwm_capture;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pwm_in = 1'b0;
    logic        meas_start;
    logic        meas_start_t;
    logic        busy, done, timeout;
    logic [15:0] high_cnt, period_cnt;
    logic [7:0]  duty;
    logic        busy_t, done_t, timeout_t;
    logic [15:0] high_t, period_t;
    logic [7:0]  duty_t;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // PWM generator controls
    logic pat_en   = 1'b0;
    logic hold_val = 1'b0;
    int   pat_h    = 1;
    int   pat_l    = 1;
    int   phase    = 0;
    int   rise_q[$];

    pwm_capture dut (
        .clk(clk), .rst_n(rst_n), .pwm_in(pwm_in), .meas_start(meas_start),
        .busy(busy), .done(done), .timeout(timeout),
        .high_cnt(high_cnt), .period_cnt(period_cnt), .duty(duty)
    );

    pwm_capture #(.TIMEOUT(16'd100)) dut_t (
        .clk(clk), .rst_n(rst_n), .pwm_in(pwm_in), .meas_start(meas_start_t),
        .busy(busy_t), .done(done_t), .timeout(timeout_t),
        .high_cnt(high_t), .period_cnt(period_t), .duty(duty_t)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Drives pwm_in 2 time units after each edge; logs the edge index of each rise.
    always @(posedge clk) begin
        #2;
        if (pat_en) begin
            if (phase == 0) rise_q.push_back(cyc);
            pwm_in = (phase < pat_h);
            phase  = (phase + 1 >= pat_h + pat_l) ? 0 : phase + 1;
        end else begin
            phase  = 0;
            pwm_in = hold_val;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input bit use_t, input int bound, input string tag, output int dcyc);
        bit seen;
        seen = 1'b0;
        dcyc = -1;
        for (int i = 0; i < bound && !seen; i++) begin
            tick();
            if ((use_t ? done_t : done) === 1'b1) begin
                seen = 1'b1;
                dcyc = cyc;
            end
        end
        check({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
    endtask

    // First rise driven after edge s-2 or later: its detect lands in WAIT_RISE.
    function automatic int first_rise(input int s);
        int r;
        r = -1;
        foreach (rise_q[i]) if (r < 0 && rise_q[i] >= s - 2) r = rise_q[i];
        return r;
    endfunction

    task automatic start_main(output int s);
        meas_start = 1'b1;
        tick();
        s = cyc;
        meas_start = 1'b0;
    endtask

    initial begin
        int s, s2, d, r, target;
        bit stable, no_done;
        rst_n = 1'b0;
        meas_start = 1'b0;
        meas_start_t = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_timeout", {31'd0, timeout}, 32'd0);
        check("rst_high", {16'd0, high_cnt}, 32'd0);
        check("rst_period", {16'd0, period_cnt}, 32'd0);
        check("rst_duty", {24'd0, duty}, 32'd0);
        check("rst_busy_t", {31'd0, busy_t}, 32'd0);
        rst_n = 1'b1;
        tick();

        // H=64 L=192
        pat_h = 64; pat_l = 192; pat_en = 1'b1;
        repeat (10) tick();
        start_main(s);
        check("h64_busy_after_start", {31'd0, busy}, 32'd1);
        wait_done(1'b0, 2000, "h64", d);
        check("h64_high", {16'd0, high_cnt}, 32'd64);
        check("h64_period", {16'd0, period_cnt}, 32'd256);
        check("h64_duty", {24'd0, duty}, 32'h40);
        check("h64_timeout", {31'd0, timeout}, 32'd0);
        check("h64_busy_in_done", {31'd0, busy}, 32'd0);
        check("h64_done_cycle", d, first_rise(s) + 256 + 11);
        tick();
        check("h64_done_one_cycle", {31'd0, done}, 32'd0);

        // meas_start during MEAS_HIGH is ignored
        for (int i = 0; i < 600; i++) begin
            tick();
            if (rise_q.size() > 0 && rise_q[$] == cyc - 1) break;
        end
        r = rise_q[$];
        repeat (10) tick();
        start_main(s);
        target = r + 256 + 23;
        for (int i = 0; i < 600 && cyc < target; i++) tick();
        start_main(s2);
        check("ign_busy", {31'd0, busy}, 32'd1);
        wait_done(1'b0, 2000, "ign", d);
        check("ign_done_cycle", d, first_rise(s) + 256 + 11);
        check("ign_high", {16'd0, high_cnt}, 32'd64);
        check("ign_duty", {24'd0, duty}, 32'h40);

        // meas_start in the DONE cycle is accepted
        start_main(s2);
        check("restart_busy", {31'd0, busy}, 32'd1);
        check("restart_done_low", {31'd0, done}, 32'd0);
        check("restart_held_high", {16'd0, high_cnt}, 32'd64);
        wait_done(1'b0, 2000, "restart", d);
        check("restart_done_cycle", d, first_rise(s2) + 256 + 11);
        check("restart_period", {16'd0, period_cnt}, 32'd256);

        // H=1 L=2: duty 0x55, 8 divide cycles between rise-detect and done
        pat_en = 1'b0; hold_val = 1'b0;
        repeat (3) tick();
        pat_h = 1; pat_l = 2; pat_en = 1'b1;
        repeat (10) tick();
        start_main(s);
        wait_done(1'b0, 200, "h1", d);
        check("h1_high", {16'd0, high_cnt}, 32'd1);
        check("h1_period", {16'd0, period_cnt}, 32'd3);
        check("h1_duty", {24'd0, duty}, 32'h55);
        check("h1_done_cycle", d, first_rise(s) + 3 + 11);

        // Timeout with input held high, then held low (TIMEOUT=100)
        pat_en = 1'b0; hold_val = 1'b1;
        repeat (5) tick();
        meas_start_t = 1'b1;
        tick();
        s = cyc;
        meas_start_t = 1'b0;
        wait_done(1'b1, 300, "tmo1", d);
        check("tmo1_done_cycle", d, s + 100);
        check("tmo1_flag", {31'd0, timeout_t}, 32'd1);
        check("tmo1_duty", {24'd0, duty_t}, 32'hFF);
        check("tmo1_high", {16'd0, high_t}, 32'd0);
        check("tmo1_period", {16'd0, period_t}, 32'd0);
        hold_val = 1'b0;
        repeat (5) tick();
        meas_start_t = 1'b1;
        tick();
        s = cyc;
        meas_start_t = 1'b0;
        wait_done(1'b1, 300, "tmo0", d);
        check("tmo0_done_cycle", d, s + 100);
        check("tmo0_flag", {31'd0, timeout_t}, 32'd1);
        check("tmo0_duty", {24'd0, duty_t}, 32'h00);

        // H=200 L=56: duty 0xC8, held for 1000 idle cycles
        pat_h = 200; pat_l = 56; pat_en = 1'b1;
        repeat (10) tick();
        start_main(s);
        wait_done(1'b0, 2000, "h200", d);
        check("h200_duty", {24'd0, duty}, 32'hC8);
        check("h200_high", {16'd0, high_cnt}, 32'd200);
        check("h200_period", {16'd0, period_cnt}, 32'd256);
        check("h200_timeout", {31'd0, timeout}, 32'd0);
        stable = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0 || duty !== 8'hC8 || high_cnt !== 16'd200 ||
                period_cnt !== 16'd256 || timeout !== 1'b0) stable = 1'b0;
        end
        check("h200_hold_1000", {31'd0, stable}, 32'd1);

        // Reset for one cycle in MEAS_LOW
        pat_en = 1'b0; hold_val = 1'b0;
        repeat (5) tick();
        start_main(s);
        repeat (5) tick();
        hold_val = 1'b1;
        repeat (64) tick();
        hold_val = 1'b0;
        repeat (20) tick();
        check("mid_busy_before_rst", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        check("mid_rst_timeout", {31'd0, timeout}, 32'd0);
        check("mid_rst_high", {16'd0, high_cnt}, 32'd0);
        check("mid_rst_period", {16'd0, period_cnt}, 32'd0);
        check("mid_rst_duty", {24'd0, duty}, 32'd0);
        pat_h = 10; pat_l = 10; pat_en = 1'b1;
        no_done = 1'b1;
        for (int i = 0; i < 600; i++) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0) no_done = 1'b0;
        end
        check("mid_rst_no_done", {31'd0, no_done}, 32'd1);
        start_main(s);
        wait_done(1'b0, 200, "after_rst", d);
        check("after_rst_done_cycle", d, first_rise(s) + 20 + 11);
        check("after_rst_high", {16'd0, high_cnt}, 32'd10);
        check("after_rst_period", {16'd0, period_cnt}, 32'd20);
        check("after_rst_duty", {24'd0, duty}, 32'h80);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
